// File: rtl/key_move_sequencer_pkg.sv
// Shared definitions for the keyboard move sequencer, the board datapath and
// the check logic: ASCII key codes, mark encodings and sequencer states.
// No ports; imported with `import key_move_sequencer_pkg::*;`.
package key_move_sequencer_pkg;

  // ASCII codes produced by the keyboard converter
  localparam logic [7:0] KEY_1     = 8'h31;
  localparam logic [7:0] KEY_2     = 8'h32;
  localparam logic [7:0] KEY_3     = 8'h33;
  localparam logic [7:0] KEY_4     = 8'h34;
  localparam logic [7:0] KEY_5     = 8'h35;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_7     = 8'h37;
  localparam logic [7:0] KEY_8     = 8'h38;
  localparam logic [7:0] KEY_9     = 8'h39;
  localparam logic [7:0] KEY_X_L   = 8'h78;
  localparam logic [7:0] KEY_X_U   = 8'h58;
  localparam logic [7:0] KEY_O_L   = 8'h6F;
  localparam logic [7:0] KEY_O_U   = 8'h4F;
  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_ESC   = 8'h1B;

  // Mark encodings shared with the datapath and check stage
  localparam logic [1:0] MOVE_NONE = 2'b00;
  localparam logic [1:0] MOVE_X    = 2'b01;
  localparam logic [1:0] MOVE_O    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_POS,
    S_GO_POS,
    S_MID,
    S_GO_MOVE,
    S_POST
  } seq_state_t;

endpackage

// File: rtl/key_move_sequencer_key_classifier.sv
// Purpose: decode one ASCII code into the key classes the sequencer acts on.
// Latency: purely combinational. Backpressure: none.
// Ports: ascii_in (code) -> is_digit/digit (1..9), is_x, is_o, is_enter, is_esc.
module key_classifier
  import key_move_sequencer_pkg::*;
(
  input  logic [7:0] ascii_in,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_x,
  output logic       is_o,
  output logic       is_enter,
  output logic       is_esc
);

  // '1'..'9' are contiguous, and the low nibble of each is the digit value
  assign is_digit = (ascii_in >= KEY_1) && (ascii_in <= KEY_9);
  assign digit    = is_digit ? ascii_in[3:0] : 4'd0;
  assign is_x     = (ascii_in == KEY_X_L) || (ascii_in == KEY_X_U);
  assign is_o     = (ascii_in == KEY_O_L) || (ascii_in == KEY_O_U);
  assign is_enter = (ascii_in == KEY_ENTER);
  assign is_esc   = (ascii_in == KEY_ESC);

endmodule

// File: rtl/key_move_sequencer.sv
// Purpose: latch a keyboard cell/mark selection, validate it on Enter and
//   replay it to the control FSM as two timed go pulses (position, then move).
// Latency: go first rises GAP_CYCLES+1 cycles after the Enter edge; a full
//   sequence takes 3*GAP_CYCLES + 2*GO_CYCLES cycles. Backpressure: none;
//   keystrokes arriving while busy are dropped, not queued.
// Ports: CLOCK_50, resetn (sync, active-low); ascii_in/key_valid keystroke;
//   occupied/game_over validation inputs; sel_pos/sel_move pending selection;
//   pos_out/move_out/go datapath handshake; busy; sticky err.
module key_move_sequencer
  import key_move_sequencer_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int GO_CYCLES  = 4,
  parameter int CNT_W      = 8
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ascii_in,
  input  logic       key_valid,
  input  logic [8:0] occupied,
  input  logic       game_over,
  output logic [3:0] sel_pos,
  output logic [1:0] sel_move,
  output logic [3:0] pos_out,
  output logic [1:0] move_out,
  output logic       go,
  output logic       busy,
  output logic       err
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GO_LAST  = CNT_W'(GO_CYCLES - 1);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic       k_digit, k_x, k_o, k_enter, k_esc;
  logic [3:0] k_digit_val;

  key_classifier u_classifier (
    .ascii_in (ascii_in),
    .is_digit (k_digit),
    .digit    (k_digit_val),
    .is_x     (k_x),
    .is_o     (k_o),
    .is_enter (k_enter),
    .is_esc   (k_esc)
  );

  // Keys are only honoured while idle
  logic key_take;
  assign key_take = (state == S_IDLE) && key_valid;

  // Occupancy of the selected cell; a zero selection never hits
  logic occ_hit;
  always_comb begin
    occ_hit = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (sel_pos == 4'(i)) occ_hit = occupied[i-1];
    end
  end

  logic reject, commit_ok, seq_done;
  assign reject    = (sel_pos == 4'd0) || (sel_move == MOVE_NONE) || occ_hit || game_over;
  assign commit_ok = key_take && k_enter && !reject;

  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    seq_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (commit_ok) state_next = S_PRE_POS;
      end
      S_PRE_POS: if (cnt == GAP_LAST) begin state_next = S_GO_POS;  cnt_next = '0; end
      S_GO_POS:  if (cnt == GO_LAST)  begin state_next = S_MID;     cnt_next = '0; end
      S_MID:     if (cnt == GAP_LAST) begin state_next = S_GO_MOVE; cnt_next = '0; end
      S_GO_MOVE: if (cnt == GO_LAST)  begin state_next = S_POST;    cnt_next = '0; end
      S_POST: begin
        if (cnt == GAP_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          seq_done   = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sel_pos  <= 4'd0;
      sel_move <= MOVE_NONE;
      pos_out  <= 4'd0;
      move_out <= MOVE_NONE;
      go       <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // go is re-timed from the state register, so it trails the GO_* states
      // by one cycle and the pulse is free of decode glitches
      go    <= (state == S_GO_POS) || (state == S_GO_MOVE);

      if (key_take) begin
        if (k_enter) begin
          // err is only touched by Enter when the commit is rejected
          if (reject) begin
            err <= 1'b1;
          end else begin
            pos_out  <= sel_pos;
            move_out <= sel_move;
            busy     <= 1'b1;
          end
        end else if (k_digit) begin
          sel_pos <= k_digit_val;
          err     <= 1'b0;
        end else if (k_x) begin
          sel_move <= MOVE_X;
          err      <= 1'b0;
        end else if (k_o) begin
          sel_move <= MOVE_O;
          err      <= 1'b0;
        end else if (k_esc) begin
          sel_pos  <= 4'd0;
          sel_move <= MOVE_NONE;
          err      <= 1'b0;
        end
      end

      if (seq_done) begin
        busy     <= 1'b0;
        sel_pos  <= 4'd0;
        sel_move <= MOVE_NONE;
      end
    end
  end

endmodule

// File: tb/tb_key_move_sequencer.sv
module tb_key_move_sequencer;
  import key_move_sequencer_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [7:0] ascii_in;
  logic       key_valid;
  logic [8:0] occupied;
  logic       game_over;
  logic [3:0] sel_pos;
  logic [1:0] sel_move;
  logic [3:0] pos_out;
  logic [1:0] move_out;
  logic       go;
  logic       busy;
  logic       err;

  key_move_sequencer #(.GAP_CYCLES(4), .GO_CYCLES(4), .CNT_W(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .ascii_in  (ascii_in),
    .key_valid (key_valid),
    .occupied  (occupied),
    .game_over (game_over),
    .sel_pos   (sel_pos),
    .sel_move  (sel_move),
    .pos_out   (pos_out),
    .move_out  (move_out),
    .go        (go),
    .busy      (busy),
    .err       (err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Each entry: {pos[3:0], move[1:0]} expected at one rising edge of go
  logic [5:0] exp_q[$];
  logic [5:0] exp_e;
  logic       go_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [7:0] code);
    @(negedge CLOCK_50);
    ascii_in  = code;
    key_valid = 1'b1;
    @(negedge CLOCK_50);
    key_valid = 1'b0;
    ascii_in  = 8'h00;
  endtask

  task automatic push_exp(input logic [3:0] p, input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({p, m});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge CLOCK_50);
    check("idle_timeout", busy, 0);
  endtask

  // Scoreboard side: every rising edge of go consumes one expectation
  always @(negedge CLOCK_50) begin
    if (go && !go_prev) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_go", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("go_pos", pos_out, exp_e[5:2]);
        check("go_move", move_out, exp_e[1:0]);
      end
    end
    go_prev = go;
  end

  initial begin
    int p0;
    resetn    = 1'b0;
    ascii_in  = 8'h00;
    key_valid = 1'b0;
    occupied  = 9'd0;
    game_over = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("rst_sel_pos", sel_pos, 0);
    check("rst_sel_move", sel_move, 0);
    check("rst_pos_out", pos_out, 0);
    check("rst_move_out", move_out, 0);
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    resetn = 1'b1;

    // Basic commit and exact pulse timing
    key(KEY_5);
    key(KEY_X_L);
    check("s1_sel_pos", sel_pos, 5);
    check("s1_sel_move", sel_move, MOVE_X);
    push_exp(4'd5, MOVE_X, 2);
    p0 = pulses;
    key(KEY_ENTER);
    for (int k = 0; k <= 20; k++) begin
      check($sformatf("s1_go_c%0d", k), go, ((k >= 5 && k <= 8) || (k >= 13 && k <= 16)) ? 1 : 0);
      check($sformatf("s1_busy_c%0d", k), busy, (k < 20) ? 1 : 0);
      if (k < 20) begin
        check("s1_pos_hold", pos_out, 5);
        check("s1_move_hold", move_out, MOVE_X);
      end
      if (k < 20) @(negedge CLOCK_50);
    end
    check("s1_sel_pos_clr", sel_pos, 0);
    check("s1_sel_move_clr", sel_move, 0);
    check("s1_pos_keep", pos_out, 5);
    check("s1_pulses", pulses - p0, 2);

    // Occupied cell rejected, then any key clears err
    occupied = 9'b000000100;
    key(KEY_3);
    key(KEY_O_L);
    key(KEY_ENTER);
    check("s2_err", err, 1);
    check("s2_busy", busy, 0);
    repeat (20) @(negedge CLOCK_50);
    check("s2_no_go", go, 0);
    key(KEY_4);
    check("s2_err_clr", err, 0);
    check("s2_sel_pos", sel_pos, 4);
    check("s2_sel_move", sel_move, MOVE_O);
    occupied = 9'd0;

    // Missing mark rejected; Esc clears selection and err
    key(KEY_ESC);
    key(KEY_2);
    key(KEY_ENTER);
    check("s3_err", err, 1);
    check("s3_busy", busy, 0);
    check("s3_sel_pos_kept", sel_pos, 2);
    key(KEY_ESC);
    check("s3_esc_pos", sel_pos, 0);
    check("s3_esc_err", err, 0);

    // Keys during GO_POS are dropped
    key(KEY_7);
    key(KEY_O_L);
    push_exp(4'd7, MOVE_O, 2);
    p0 = pulses;
    key(KEY_ENTER);
    repeat (5) @(negedge CLOCK_50);
    check("s4_in_go", go, 1);
    key(KEY_9);
    key(KEY_ENTER);
    check("s4_sel_pos", sel_pos, 7);
    check("s4_pos_out", pos_out, 7);
    wait_idle();
    repeat (12) @(negedge CLOCK_50);
    check("s4_pulses", pulses - p0, 2);
    check("s4_sel_pos_clr", sel_pos, 0);

    // Reset in MID aborts; a fresh commit afterwards works
    key(KEY_8);
    key(KEY_X_L);
    push_exp(4'd8, MOVE_X, 1);
    p0 = pulses;
    key(KEY_ENTER);
    repeat (9) @(negedge CLOCK_50);
    check("s5_mid_busy", busy, 1);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    check("s5_go", go, 0);
    check("s5_busy", busy, 0);
    check("s5_sel_pos", sel_pos, 0);
    check("s5_sel_move", sel_move, 0);
    check("s5_pos_out", pos_out, 0);
    check("s5_move_out", move_out, 0);
    check("s5_err", err, 0);
    repeat (10) @(negedge CLOCK_50);
    check("s5_abort_pulses", pulses - p0, 1);
    key(KEY_6);
    key(KEY_O_U);
    push_exp(4'd6, MOVE_O, 2);
    p0 = pulses;
    key(KEY_ENTER);
    check("s5_busy_new", busy, 1);
    wait_idle();
    repeat (3) @(negedge CLOCK_50);
    check("s5_new_pulses", pulses - p0, 2);

    // Game over blocks commits; uppercase marks decode
    game_over = 1'b1;
    key(KEY_1);
    key(KEY_O_U);
    check("s6_sel_move_O", sel_move, MOVE_O);
    key(KEY_X_U);
    check("s6_sel_move_X", sel_move, MOVE_X);
    key(KEY_ENTER);
    check("s6_err", err, 1);
    check("s6_busy", busy, 0);
    repeat (20) @(negedge CLOCK_50);
    check("s6_no_go", go, 0);
    game_over = 1'b0;

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_move_sequencer.md
Name: key_move_sequencer

Overview:
- Sits between the keyboard ASCII converter and the turn control FSM / board datapath.
- Registers keystrokes as a pending selection: cell '1'-'9' plus mark 'x'/'o'. On Enter it validates the selection against board occupancy and game state.
- A valid selection is replayed as a timed two-phase go handshake. Phase one presents the position with a go pulse. Phase two presents the move with a go pulse.
- This replaces the manual SW[0] go switch and the level-sensitive key decode.

Parameters:
GAP_CYCLES, 4, idle cycles with go low before and after each go pulse (min 1)
GO_CYCLES, 4, cycles go is held high per phase (min 1)
CNT_W, 8, width of the shared phase counter; must hold max(GAP_CYCLES, GO_CYCLES)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  reset, synchronous, active-low
ascii_in  in  8  ASCII code of the last key
key_valid  in  1  one-cycle strobe: ascii_in holds a new keystroke
occupied  in  9  bit i-1 set when cell i is non-empty
game_over  in  1  high once the check stage has ended the game
sel_pos  out  4  pending cell, 0 = none (to HEX5)
sel_move  out  2  pending mark, 01=X, 10=O, 00=none (to HEX4)
pos_out  out  4  position presented to the datapath
move_out  out  2  move presented to the datapath
go  out  1  handshake to the control FSM
busy  out  1  high while a commit sequence is running
err  out  1  sticky reject flag

Behaviour:
- Reset values: every output is 0; FSM is in IDLE; counter is 0. Reset mid-sequence aborts it immediately and go drops on the next edge.
- Key decode applies only in IDLE on a key_valid cycle. Key_valid cycles in any other state are ignored and not queued.
  - 0x31-0x39: sel_pos <= 1..9.
  - 0x78/0x58: sel_move <= 01.
  - 0x6F/0x4F: sel_move <= 10.
  - 0x1B (Esc): sel_pos <= 0, sel_move <= 0.
  - 0x0D (Enter): commit request.
  - Any other code: no change.
  - Any accepted key except Enter clears err.
- Commit check on Enter, all combinational on current inputs. Reject when any of the following holds:
  - sel_pos == 0, or
  - sel_move == 0, or
  - occupied[sel_pos-1] == 1, or
  - game_over == 1.
  - Reject: err <= 1; selection kept; stay in IDLE.
  - Accept: pos_out <= sel_pos, move_out <= sel_move, busy <= 1, counter <= 0; next state PRE_POS.
- FSM states and transitions (counter cleared on every state change):
  - IDLE: waits for an accepted commit.
  - PRE_POS: go=0; after GAP_CYCLES -> GO_POS.
  - GO_POS: go=1; after GO_CYCLES -> MID.
  - MID: go=0; after GAP_CYCLES -> GO_MOVE.
  - GO_MOVE: go=1; after GO_CYCLES -> POST.
  - POST: go=0; after GAP_CYCLES -> IDLE. On this exit: busy <= 0, sel_pos <= 0, sel_move <= 0.
- Latency: go first rises GAP_CYCLES+1 cycles after the Enter strobe edge. A full sequence lasts 3*GAP_CYCLES + 2*GO_CYCLES cycles from PRE_POS entry to IDLE.
- Hold requirement: pos_out and move_out stay constant from acceptance through return to IDLE. They keep their last values afterwards.
- go is a registered output, so it is glitch-free.
- game_over asserting mid-sequence does not abort; the sequence completes.
- Simultaneous events: in the acceptance cycle, Enter takes priority over the err clear (err is unaffected).

Decomposition:
- Shared package holds:
  - ASCII constants: KEY_1..KEY_9, KEY_X_L/U, KEY_O_L/U, KEY_ENTER, KEY_ESC.
  - Move encodings: MOVE_NONE=00, MOVE_X=01, MOVE_O=10. These are also used by the datapath and the check logic.
  - Sequencer state enum.
- One natural sub-module, key_classifier (combinational). It maps ascii_in to {is_digit, digit[3:0], is_x, is_o, is_enter, is_esc}. The FSM and counter stay in key_move_sequencer.

Test Plan:
- Reset, then keys '5','x',Enter with occupied=0:
  - sel_pos=5, sel_move=01.
  - go high on cycles 5-8 and 13-16 after Enter (defaults), pos_out=5 and move_out=01 throughout.
  - busy falls and sel_* clear at cycle 20.
- Keys '3','o',Enter with occupied[2]=1 -> no go pulse, err=1. Then key '4' -> err=0, sel_pos=4, sel_move=10.
- Enter with sel_move=0 -> err=1, busy stays 0. Then Esc -> sel_pos=0, err=0.
- During GO_POS, strobe '9' and Enter -> ignored: sel_pos and pos_out unchanged, exactly two go pulses.
- resetn low for 1 cycle during MID -> next edge go=0, busy=0, all outputs 0, state IDLE. A new commit then works normally.
- game_over=1, keys '1','x',Enter -> err=1, go stays 0. Uppercase 'X' gives sel_move=01.
